mini_sweep_ctrl: RTL and testbench

Upstream stimulus sequencer and downstream capture stage for the 4-input combinational minimisation block (`mini_1`, port a[3:0] -> z). On a start pulse it does the following:
- walks the input vector through all 2^N_IN values;
- waits a programmable settle time per vector;
- samples z into a truth-table register;
- compares the result against a latched expected minterm mask.

It replaces free-running bench counters with a reusable, synthesizable sweep engine for on-board self-check of combinational stages.

---
 rtl/mini_sweep_ctrl.sv | 108 ++++++++++
 tb/tb_mini_sweep_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mini_sweep_ctrl.sv
// Sweep engine for a combinational block: drives every input vector in turn,
// waits a programmable settle time, captures z into a truth table and compares
// the captured table against an expected mask latched at start.
module mini_sweep_ctrl #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [(1<<N_IN)-1:0]    expected,
  output logic [N_IN-1:0]         a_out,
  input  logic                    z_in,
  output logic                    busy,
  output logic                    done,
  output logic [(1<<N_IN)-1:0]    tt,
  output logic                    match,
  output logic [N_IN:0]           mismatch_cnt,
  output logic [N_IN-1:0]         first_bad,
  output logic                    first_bad_vld
);

  localparam int NV = 1 << N_IN;
  localparam logic [3:0]      SET  = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST = '1;

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, FIN} state_t;

  state_t          state, nxt;
  logic [3:0]      settle_cnt;
  logic [NV-1:0]   exp_l;
  logic            z_bad;

  // Next-state selection; SETTLE=0 skips the wait window entirely.
  always_comb begin
    nxt   = state;
    z_bad = (z_in != exp_l[a_out]);
    case (state)
      IDLE:    if (start) nxt = (SETTLE == 0) ? SAMPLE : WAIT;
      WAIT:    if (settle_cnt <= 4'd1) nxt = SAMPLE;
      SAMPLE:  if (a_out == LAST) nxt = FIN;
               else               nxt = (SETTLE == 0) ? SAMPLE : WAIT;
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // State register plus sweep datapath; results hold between sweeps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      a_out         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      tt            <= '0;
      match         <= 1'b0;
      mismatch_cnt  <= '0;
      first_bad     <= '0;
      first_bad_vld <= 1'b0;
      exp_l         <= '0;
      settle_cnt    <= '0;
    end else begin
      state <= nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            exp_l         <= expected;
            tt            <= '0;
            mismatch_cnt  <= '0;
            first_bad     <= '0;
            first_bad_vld <= 1'b0;
            match         <= 1'b0;
            a_out         <= '0;
            settle_cnt    <= SET;
            busy          <= 1'b1;
          end
        end
        WAIT: settle_cnt <= settle_cnt - 4'd1;
        SAMPLE: begin
          tt[a_out] <= z_in;
          if (z_bad) begin
            mismatch_cnt <= mismatch_cnt + 1'b1;
            if (!first_bad_vld) begin
              first_bad     <= a_out;
              first_bad_vld <= 1'b1;
            end
          end
          // Terminate on the top vector rather than letting a_out wrap.
          if (a_out == LAST) begin
            busy <= 1'b0;
          end else begin
            a_out      <= a_out + 1'b1;
            settle_cnt <= SET;
          end
        end
        FIN: begin
          // tt already holds the last sampled bit by this cycle.
          done  <= 1'b1;
          match <= (tt == exp_l);
          a_out <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mini_sweep_ctrl.sv
// Directed bench for mini_sweep_ctrl: two instances (SETTLE=1 and SETTLE=0)
// checked every cycle against a timeline model plus literal spot checks.
module tb_mini_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       start, busy, done, match, fbv, z_in, zsel;
  logic [1:0][15:0] expected, tt;
  logic [1:0][3:0]  a_out, fb;
  logic [1:0][4:0]  mc;

  int pass_cnt = 0;
  int total    = 0;
  bit chk_en   = 0;

  // index 0: SETTLE=1, index 1: SETTLE=0
  mini_sweep_ctrl #(.N_IN(4), .SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .start(start[0]), .expected(expected[0]),
    .a_out(a_out[0]), .z_in(z_in[0]), .busy(busy[0]), .done(done[0]),
    .tt(tt[0]), .match(match[0]), .mismatch_cnt(mc[0]),
    .first_bad(fb[0]), .first_bad_vld(fbv[0]));

  mini_sweep_ctrl #(.N_IN(4), .SETTLE(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start[1]), .expected(expected[1]),
    .a_out(a_out[1]), .z_in(z_in[1]), .busy(busy[1]), .done(done[1]),
    .tt(tt[1]), .match(match[1]), .mismatch_cnt(mc[1]),
    .first_bad(fb[1]), .first_bad_vld(fbv[1]));

  function automatic logic zf(logic s, logic [3:0] v);
    return s ? (v[3] & v[1]) : v[0];
  endfunction

  assign z_in[0] = zf(zsel[0], a_out[0]);
  assign z_in[1] = zf(zsel[1], a_out[1]);

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  // Model: edges since the accepted start; each vector takes P=SETTLE+1 edges,
  // vector v is sampled at edge (v+1)*P, FIN at 16*P, done visible at 16*P+1.
  bit          m_sw[2];
  int          m_t[2];
  logic [15:0] m_exp[2];
  logic        m_z[2];

  function automatic int per(int d);
    return (d == 0) ? 2 : 1;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_sw[d]  <= 1'b0;
        m_t[d]   <= 0;
        m_exp[d] <= '0;
      end else if (start[d] && (!m_sw[d] || m_t[d] >= 16*per(d) + 1)) begin
        m_sw[d]  <= 1'b1;
        m_t[d]   <= 0;
        m_exp[d] <= expected[d];
        m_z[d]   <= zsel[d];
      end else if (m_sw[d] && m_t[d] < 16*per(d) + 2) begin
        m_t[d] <= m_t[d] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int          p, l, t, e_mc, e_a;
        logic [15:0] e_tt;
        logic [3:0]  e_fb;
        logic        e_fbv;
        p = per(d); l = 16*p; t = m_t[d];
        e_tt = '0; e_mc = 0; e_fb = '0; e_fbv = 1'b0; e_a = 0;
        if (m_sw[d]) begin
          for (int v = 0; v < 16; v++) begin
            if ((v+1)*p <= t) begin
              e_tt[v] = zf(m_z[d], 4'(v));
              if (e_tt[v] != m_exp[d][v]) begin
                e_mc++;
                if (!e_fbv) begin e_fb = 4'(v); e_fbv = 1'b1; end
              end
            end
          end
          e_a = (t < l) ? t / p : ((t == l) ? 15 : 0);
        end
        chk($sformatf("cyc_a_out%0d", d), a_out[d], e_a);
        chk($sformatf("cyc_busy%0d", d), busy[d], m_sw[d] && t < l);
        chk($sformatf("cyc_done%0d", d), done[d], m_sw[d] && t == l + 1);
        chk($sformatf("cyc_tt%0d", d), tt[d], e_tt);
        chk($sformatf("cyc_mcnt%0d", d), mc[d], e_mc);
        chk($sformatf("cyc_fb%0d", d), fb[d], e_fb);
        chk($sformatf("cyc_fbv%0d", d), fbv[d], e_fbv);
        chk($sformatf("cyc_match%0d", d), match[d],
            m_sw[d] && t >= l + 1 && e_tt == m_exp[d]);
      end
    end
  end

  task automatic pulse(int d, logic [15:0] e, logic zs);
    @(negedge clk);
    expected[d] = e; zsel[d] = zs; start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  // Counts negedges after the accepting edge until done is seen.
  task automatic wait_done(int d, int n0, output int n);
    n = n0;
    while (!done[d] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done[d]) chk("done_timeout", 0, 1);
  endtask

  int n;

  initial begin
    start = '0; expected = '0; zsel = '0; rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_tt", tt[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_fbv", fbv[1], 0);
    rst = 1'b0;

    // T1: z=a[0], exact match, SETTLE=1
    pulse(0, 16'hAAAA, 1'b0);
    wait_done(0, 0, n);
    chk("t1_latency", n, 33);
    chk("t1_tt", tt[0], 16'hAAAA);
    chk("t1_match", match[0], 1);
    chk("t1_mcnt", mc[0], 0);
    chk("t1_fbv", fbv[0], 0);

    // T2: start during the done cycle, one mismatch at vector 0
    expected[0] = 16'hAAAB; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    chk("t2_busy", busy[0], 1);
    chk("t2_tt_clr", tt[0], 0);
    wait_done(0, 0, n);
    chk("t2_tt", tt[0], 16'hAAAA);
    chk("t2_match", match[0], 0);
    chk("t2_mcnt", mc[0], 1);
    chk("t2_fb", fb[0], 0);
    chk("t2_fbv", fbv[0], 1);

    // T3: every bit wrong
    pulse(0, 16'h5555, 1'b0);
    wait_done(0, 0, n);
    chk("t3_mcnt", mc[0], 5'b10000);
    chk("t3_fb", fb[0], 0);
    chk("t3_match", match[0], 0);

    // T4: SETTLE=0, z=a[3]&a[1]; restart at edge 5 and expected toggles ignored
    pulse(1, 16'hCC00, 1'b1);
    repeat (4) @(negedge clk);
    start[1] = 1'b1; expected[1] = 16'hFFFF;
    @(negedge clk);
    start[1] = 1'b0; expected[1] = 16'h0000;
    wait_done(1, 5, n);
    chk("t4_latency", n, 17);
    chk("t4_tt", tt[1], 16'hCC00);
    chk("t4_match", match[1], 1);

    // T5: reset at vector 7 (with start on the other instance), then clean sweep
    pulse(0, 16'hAAAA, 1'b0);
    n = 0;
    while (a_out[0] != 4'd7 && n < 100) begin @(negedge clk); n++; end
    chk("t5_reach7", a_out[0], 7);
    rst = 1'b1; start[1] = 1'b1;
    @(negedge clk);
    rst = 1'b0; start[1] = 1'b0;
    chk("t5_busy", busy[0], 0);
    chk("t5_a_out", a_out[0], 0);
    chk("t5_tt", tt[0], 0);
    chk("t5_busy_s0", busy[1], 0);
    chk("t5_tt_s0", tt[1], 0);
    repeat (40) @(negedge clk);
    chk("t5_no_done", done[0], 0);
    pulse(0, 16'hAAAA, 1'b0);
    wait_done(0, 0, n);
    chk("t5_latency", n, 33);
    chk("t5_tt2", tt[0], 16'hAAAA);
    chk("t5_match", match[0], 1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
